// File: rtl/conv_pkg.sv
`default_nettype none
// conv_pkg: state encoding, staging-buffer select codes and K field width shared by the
// convolution stream transmit and receive sides. Rev 1.0

package conv_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND_W = 2'd1,
        SEND_B = 2'd2,
        SEND_X = 2'd3
    } tx_state_t;

    localparam logic [1:0] WR_SEL_W = 2'd0;
    localparam logic [1:0] WR_SEL_B = 2'd1;
    localparam logic [1:0] WR_SEL_X = 2'd2;

    function automatic int k_bits(input int maxk);
        return $clog2(maxk + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/axis_skid.sv
`default_nettype none
// axis_skid: 2-entry output buffer with registered outputs; the producer uses level to
// pace itself, so a push never arrives when both entries are occupied. Rev 1.0

module axis_skid #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       level
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             push;
    logic             pop;

    assign push      = in_valid && (count != 2'd2);
    assign pop       = out_valid && out_ready;
    assign out_valid = (count != 2'd0);
    assign out_data  = mem[rd_ptr];
    assign level     = count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

`default_nettype wire

// File: rtl/conv_stream_tx.sv
`default_nettype none
// conv_stream_tx: stages W/B/X buffers and streams a W,B,X packet over AXI-Stream. Rev 1.0
// Build option CONV_TX_TLAST_EN adds OUTPUT_TLAST on the final X word of each packet.

module conv_stream_tx
    import conv_pkg::*;
#(
    parameter  int INW    = 24,
    parameter  int R      = 9,
    parameter  int C      = 8,
    parameter  int MAXK   = 4,
    localparam int K_BITS = k_bits(MAXK)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [1:0]             wr_sel,
    input  logic [$clog2(R*C)-1:0] wr_addr,
    input  logic [INW-1:0]         wr_data,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [K_BITS-1:0]      cmd_k,
    input  logic                   cmd_new_w,
    output logic [INW-1:0]         OUTPUT_TDATA,
    output logic                   OUTPUT_TVALID,
    input  logic                   OUTPUT_TREADY,
    output logic [K_BITS:0]        OUTPUT_TUSER,
`ifdef CONV_TX_TLAST_EN
    output logic                   OUTPUT_TLAST,
`endif
    output logic                   busy
);

    localparam int W_DEPTH = MAXK * MAXK;
    localparam int X_DEPTH = R * C;
    localparam int X_AW    = $clog2(X_DEPTH);
    localparam int W_AW    = (W_DEPTH > 1) ? $clog2(W_DEPTH) : 1;
    localparam int CNT_W   = $clog2(((X_DEPTH > W_DEPTH) ? X_DEPTH : W_DEPTH) + 1);
    localparam logic [CNT_W-1:0] X_WORDS = CNT_W'(X_DEPTH);
`ifdef CONV_TX_TLAST_EN
    localparam int SKW = INW + 1;
`else
    localparam int SKW = INW;
`endif

    logic [INW-1:0]    w_buf [W_DEPTH];
    logic [INW-1:0]    x_buf [X_DEPTH];
    logic [INW-1:0]    b_reg;

    tx_state_t         state;
    tx_state_t         next_state;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  kk;
    logic [K_BITS-1:0] k_lat;
    logic [K_BITS-1:0] k_eff;
    logic              new_w_lat;
    logic              accept;
    logic              issue;
    logic              pop;
    logic              space_ok;
    logic              w_last;
    logic [2:0]        inflight;
    logic [1:0]        skid_level;
    logic              rd_valid;
    logic [INW-1:0]    read_data;
    logic [SKW-1:0]    next_word;
    logic [SKW-1:0]    rd_word;
    logic [SKW-1:0]    skid_out;

    assign cmd_ready    = (state == IDLE) && reset;
    assign busy         = (state != IDLE);
    assign accept       = cmd_valid && cmd_ready;
    assign pop          = OUTPUT_TVALID && OUTPUT_TREADY;
    assign w_last       = (cnt == kk - CNT_W'(1));
    assign k_eff        = (cmd_k == '0 || int'(cmd_k) > MAXK) ? K_BITS'(MAXK) : cmd_k;
    assign OUTPUT_TUSER = {k_lat, new_w_lat};
    assign OUTPUT_TDATA = skid_out[INW-1:0];

    // Words held after this cycle: skid contents plus the read in flight, minus this pop.
    // Issuing only while that is at most 1 keeps the 2-entry skid from ever overflowing.
    assign inflight = 3'(skid_level) + 3'(rd_valid) - 3'(pop);
    assign space_ok = (inflight <= 3'd1);

    always_ff @(posedge clk) begin
        if (wr_en && !busy) begin
            case (wr_sel)
                WR_SEL_W: if (int'(wr_addr) < W_DEPTH) w_buf[W_AW'(wr_addr)] <= wr_data;
                WR_SEL_B: b_reg <= wr_data;
                WR_SEL_X: if (int'(wr_addr) < X_DEPTH) x_buf[wr_addr] <= wr_data;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        issue      = 1'b0;
        case (state)
            IDLE: begin
                if (accept) next_state = cmd_new_w ? SEND_W : SEND_X;
            end
            SEND_W: begin
                issue = space_ok;
                if (space_ok && w_last) next_state = SEND_B;
            end
            SEND_B: begin
                issue = space_ok;
                if (space_ok) next_state = SEND_X;
            end
            SEND_X: begin
                issue = space_ok && (cnt != X_WORDS);
                // Leave only on the handshake of the last buffered word.
                if (cnt == X_WORDS && !rd_valid &&
                    (skid_level == 2'd0 || (skid_level == 2'd1 && pop))) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            kk        <= '0;
            k_lat     <= '0;
            new_w_lat <= 1'b0;
        end else if (accept) begin
            cnt       <= '0;
            kk        <= CNT_W'(k_eff) * CNT_W'(k_eff);
            k_lat     <= k_eff;
            new_w_lat <= cmd_new_w;
        end else if (issue) begin
            cnt <= (state == SEND_X || (state == SEND_W && !w_last)) ? cnt + CNT_W'(1) : '0;
        end
    end

    always_comb begin
        read_data = b_reg;
        case (state)
            SEND_W:  read_data = w_buf[W_AW'(cnt)];
            SEND_X:  read_data = x_buf[X_AW'(cnt)];
            default: ;
        endcase
`ifdef CONV_TX_TLAST_EN
        next_word = {(state == SEND_X) && (cnt == X_WORDS - CNT_W'(1)), read_data};
`else
        next_word = read_data;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_valid <= 1'b0;
            rd_word  <= '0;
        end else begin
            rd_valid <= issue;
            if (issue) rd_word <= next_word;
        end
    end

    axis_skid #(
        .WIDTH (SKW)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (rd_valid),
        .in_data   (rd_word),
        .out_valid (OUTPUT_TVALID),
        .out_ready (OUTPUT_TREADY),
        .out_data  (skid_out),
        .level     (skid_level)
    );

`ifdef CONV_TX_TLAST_EN
    assign OUTPUT_TLAST = OUTPUT_TVALID && skid_out[INW];
`endif

endmodule

`default_nettype wire
